vx_tma_req_asm: RTL and testbench

VX_TMA_REQ_ASM -- requirements
Module: VX_tma_req_asm

---
 rtl/vx_tma_req_asm.sv | 145 ++++++++++++++
 tb/tb_vx_tma_req_asm.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vx_tma_req_asm.sv
// rtl/vx_tma_req_asm.sv - assembles a TMA request from a five-uop SETUP0/SETUP1/COORD01/COORD23/ISSUE sequence
module vx_tma_req_asm #(
  parameter int WID_WIDTH  = 4,
  parameter int UUID_WIDTH = 44,
  parameter int DESC_W     = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [WID_WIDTH-1:0]  in_wid,
  input  logic [UUID_WIDTH-1:0] in_uuid,
  input  logic [31:0]           in_rs1_data,
  input  logic [31:0]           in_rs2_data,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [WID_WIDTH-1:0]  req_wid,
  output logic [UUID_WIDTH-1:0] req_uuid,
  output logic [DESC_W-1:0]     req_desc_id,
  output logic [15:0]           req_bar_addr,
  output logic [15:0]           req_flags,
  output logic [31:0]           req_smem_addr,
  output logic [159:0]          req_coords,
  output logic                  seq_err
);

  localparam logic [2:0] OP_SETUP0  = 3'd0;
  localparam logic [2:0] OP_SETUP1  = 3'd1;
  localparam logic [2:0] OP_COORD01 = 3'd2;
  localparam logic [2:0] OP_COORD23 = 3'd3;
  localparam logic [2:0] OP_ISSUE   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_GOT_S0, S_GOT_S1, S_GOT_C01, S_GOT_C23, S_HOLD
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            w_legal_op;
  logic                  w_accept;
  logic                  w_wid_bad;
  logic                  w_viol;
  logic                  w_cap_ok;
  logic                  r_seq_err;
  logic [WID_WIDTH-1:0]  r_wid;
  logic [UUID_WIDTH-1:0] r_uuid;
  logic [DESC_W-1:0]     r_desc_id;
  logic [15:0]           r_bar_addr;
  logic [15:0]           r_flags;
  logic [31:0]           r_smem_addr;
  logic [4:0][31:0]      r_coords;

  always_comb begin
    w_legal_op = OP_SETUP0;
    case (r_state)
      S_GOT_S0:  w_legal_op = OP_SETUP1;
      S_GOT_S1:  w_legal_op = OP_COORD01;
      S_GOT_C01: w_legal_op = OP_COORD23;
      S_GOT_C23: w_legal_op = OP_ISSUE;
      default:   w_legal_op = OP_SETUP0;
    endcase
  end

  assign in_ready  = (r_state != S_HOLD);
  assign w_accept  = in_valid && in_ready;
  // Every uop after SETUP0 must belong to the warp that opened the sequence.
  assign w_wid_bad = (r_state != S_IDLE) && (in_wid != r_wid);
  assign w_viol    = w_accept && ((in_op != w_legal_op) || w_wid_bad);
  assign w_cap_ok  = w_accept && !w_viol;

  always_comb begin
    w_next = r_state;
    if (w_viol) begin
      w_next = (in_op == OP_SETUP0) ? S_GOT_S0 : S_IDLE;
    end else if (w_accept) begin
      case (r_state)
        S_IDLE:    w_next = S_GOT_S0;
        S_GOT_S0:  w_next = S_GOT_S1;
        S_GOT_S1:  w_next = S_GOT_C01;
        S_GOT_C01: w_next = S_GOT_C23;
        S_GOT_C23: w_next = S_HOLD;
        default:   w_next = r_state;
      endcase
    end else if (r_state == S_HOLD && req_ready) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_seq_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_seq_err <= w_viol;
    end
  end

  // SETUP0 captures whether it is the legal opener or a restart after a violation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wid       <= '0;
      r_uuid      <= '0;
      r_desc_id   <= '0;
      r_bar_addr  <= '0;
      r_flags     <= '0;
      r_smem_addr <= '0;
      r_coords    <= '0;
    end else begin
      if (w_accept && in_op == OP_SETUP0) begin
        r_desc_id  <= in_rs1_data[DESC_W-1:0];
        r_bar_addr <= in_rs2_data[15:0];
        r_wid      <= in_wid;
        r_uuid     <= in_uuid;
      end
      if (w_cap_ok && in_op == OP_SETUP1) begin
        r_smem_addr <= in_rs1_data;
        r_flags     <= in_rs2_data[31:16];
      end
      if (w_cap_ok && in_op == OP_COORD01) begin
        r_coords[0] <= in_rs1_data;
        r_coords[1] <= in_rs2_data;
      end
      if (w_cap_ok && in_op == OP_COORD23) begin
        r_coords[2] <= in_rs1_data;
        r_coords[3] <= in_rs2_data;
      end
      if (w_cap_ok && in_op == OP_ISSUE) begin
        r_coords[4] <= in_rs1_data;
      end
    end
  end

  assign req_valid     = (r_state == S_HOLD);
  assign seq_err       = r_seq_err;
  assign req_wid       = r_wid;
  assign req_uuid      = r_uuid;
  assign req_desc_id   = r_desc_id;
  assign req_bar_addr  = r_bar_addr;
  assign req_flags     = r_flags;
  assign req_smem_addr = r_smem_addr;
  assign req_coords    = r_coords;

endmodule

// File: tb/tb_vx_tma_req_asm.sv
// tb/tb_vx_tma_req_asm.sv - directed table-driven bench for vx_tma_req_asm
module tb_vx_tma_req_asm;

  localparam logic [2:0] S0  = 3'd0;
  localparam logic [2:0] S1  = 3'd1;
  localparam logic [2:0] C01 = 3'd2;
  localparam logic [2:0] C23 = 3'd3;
  localparam logic [2:0] ISS = 3'd4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [3:0]   in_wid;
  logic [43:0]  in_uuid;
  logic [31:0]  in_rs1_data;
  logic [31:0]  in_rs2_data;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_wid;
  logic [43:0]  req_uuid;
  logic [4:0]   req_desc_id;
  logic [15:0]  req_bar_addr;
  logic [15:0]  req_flags;
  logic [31:0]  req_smem_addr;
  logic [159:0] req_coords;
  logic         seq_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_tma_req_asm dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_wid(in_wid), .in_uuid(in_uuid),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wid(req_wid), .req_uuid(req_uuid), .req_desc_id(req_desc_id),
    .req_bar_addr(req_bar_addr), .req_flags(req_flags),
    .req_smem_addr(req_smem_addr), .req_coords(req_coords),
    .seq_err(seq_err)
  );

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [3:0]  wid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        rr;
    logic        e_ir;
    logic        e_rv;
    logic        e_se;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic v, logic [2:0] op, logic [3:0] wid, logic [31:0] rs1,
                              logic [31:0] rs2, logic rr, logic e_ir, logic e_rv, logic e_se);
    vec_t t;
    t.v = v; t.op = op; t.wid = wid; t.rs1 = rs1; t.rs2 = rs2; t.rr = rr;
    t.e_ir = e_ir; t.e_rv = e_rv; t.e_se = e_se;
    tbl.push_back(t);
  endfunction

  task automatic chk(string name, logic [159:0] act, logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one cycle of inputs at the negedge; outputs are then sampled mid-cycle.
  task automatic drive(logic v, logic [2:0] op, logic [3:0] wid, logic [31:0] rs1,
                       logic [31:0] rs2, logic rr);
    @(negedge clk);
    in_valid = v; in_op = op; in_wid = wid; in_rs1_data = rs1; in_rs2_data = rs2;
    req_ready = rr;
    #1;
  endtask

  task automatic idle(logic rr);
    drive(1'b0, S0, 4'd0, 32'd0, 32'd0, rr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    in_valid = 1'b0;
    #1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic send_legal(logic [3:0] wid, logic [31:0] desc, logic [31:0] bar,
                            logic [31:0] base);
    drive(1'b1, S0,  wid, desc, bar, 1'b1);
    drive(1'b1, S1,  wid, 32'h0000_8000, 32'h0005_0000, 1'b1);
    drive(1'b1, C01, wid, base, base + 1, 1'b1);
    drive(1'b1, C23, wid, base + 2, base + 3, 1'b1);
    drive(1'b1, ISS, wid, base + 4, 32'hDEAD_BEEF, 1'b1);
  endtask

  logic [159:0] exp_c;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_wid = 4'd0;
    in_uuid = 44'h123_4567_89AB; in_rs1_data = '0; in_rs2_data = '0; req_ready = 1'b0;
    #12;
    chk("rst_in_ready", {159'd0, in_ready}, 160'd1);
    chk("rst_req_valid", {159'd0, req_valid}, 160'd0);
    chk("rst_seq_err", {159'd0, seq_err}, 160'd0);
    chk("rst_coords", req_coords, 160'd0);
    chk("rst_desc", {155'd0, req_desc_id}, 160'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // legal sequence with an idle bubble
    add(1, S0, 2, 3, 32'h1240, 1,  1, 0, 0);
    add(1, S1, 2, 32'h8000, 32'h0005_0000, 1,  1, 0, 0);
    add(0, C01, 2, 0, 0, 1,  1, 0, 0);
    add(1, C01, 2, 10, 11, 1,  1, 0, 0);
    add(1, C23, 2, 12, 13, 1,  1, 0, 0);
    add(1, ISS, 2, 14, 0, 1,  1, 0, 0);
    add(0, S0, 0, 0, 0, 1,  0, 1, 0);
    add(0, S0, 0, 0, 0, 1,  1, 0, 0);
    // out-of-order op
    add(1, S0, 2, 3, 32'h1240, 1,  1, 0, 0);
    add(1, C01, 2, 10, 11, 1,  1, 0, 0);
    add(0, S0, 0, 0, 0, 1,  1, 0, 1);
    add(0, S0, 0, 0, 0, 1,  1, 0, 0);
    // undefined op code, then warp mismatch
    add(1, 3'd5, 0, 0, 0, 1,  1, 0, 0);
    add(1, S0, 1, 1, 0, 1,  1, 0, 1);
    add(1, S1, 3, 0, 0, 1,  1, 0, 0);
    add(0, S0, 0, 0, 0, 1,  1, 0, 1);
    add(0, S0, 0, 0, 0, 1,  1, 0, 0);
    // legal sequence after errors, uops in HOLD are ignored
    add(1, S0, 2, 3, 32'h1240, 1,  1, 0, 0);
    add(1, S1, 2, 32'h8000, 32'h0005_0000, 1,  1, 0, 0);
    add(1, C01, 2, 10, 11, 1,  1, 0, 0);
    add(1, C23, 2, 12, 13, 1,  1, 0, 0);
    add(1, ISS, 2, 14, 0, 1,  1, 0, 0);
    add(1, ISS, 2, 0, 0, 0,  0, 1, 0);
    add(1, S0, 2, 0, 0, 1,  0, 1, 0);
    add(1, S0, 2, 0, 0, 1,  1, 0, 0);
    add(0, S0, 0, 0, 0, 1,  1, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].wid, tbl[i].rs1, tbl[i].rs2, tbl[i].rr);
      chk($sformatf("vec%0d_in_ready", i), {159'd0, in_ready}, {159'd0, tbl[i].e_ir});
      chk($sformatf("vec%0d_req_valid", i), {159'd0, req_valid}, {159'd0, tbl[i].e_rv});
      chk($sformatf("vec%0d_seq_err", i), {159'd0, seq_err}, {159'd0, tbl[i].e_se});
    end

    // basic request fields
    do_reset();
    exp_c = {32'd14, 32'd13, 32'd12, 32'd11, 32'd10};
    send_legal(4'd2, 32'd3, 32'h0000_1240, 32'd10);
    chk("a_rv_issue_cycle", {159'd0, req_valid}, 160'd0);
    idle(1'b1);
    chk("a_req_valid", {159'd0, req_valid}, 160'd1);
    chk("a_desc", {155'd0, req_desc_id}, 160'd3);
    chk("a_bar", {144'd0, req_bar_addr}, 160'h1240);
    chk("a_smem", {128'd0, req_smem_addr}, 160'h8000);
    chk("a_flags", {144'd0, req_flags}, 160'h5);
    chk("a_wid", {156'd0, req_wid}, 160'd2);
    chk("a_uuid", {116'd0, req_uuid}, {116'd0, 44'h123_4567_89AB});
    chk("a_coords", req_coords, exp_c);

    // backpressure for four cycles
    idle(1'b1);
    exp_c = {32'd24, 32'd23, 32'd22, 32'd21, 32'd20};
    send_legal(4'd2, 32'd3, 32'h0000_1240, 32'd20);
    for (int k = 0; k < 4; k++) begin
      idle(1'b0);
      chk($sformatf("b_in_ready%0d", k), {159'd0, in_ready}, 160'd0);
      chk($sformatf("b_req_valid%0d", k), {159'd0, req_valid}, 160'd1);
      chk($sformatf("b_coords%0d", k), req_coords, exp_c);
      chk($sformatf("b_smem%0d", k), {128'd0, req_smem_addr}, 160'h8000);
    end
    idle(1'b1);
    chk("b_rv_hs", {159'd0, req_valid}, 160'd1);
    idle(1'b1);
    chk("b_idle_ir", {159'd0, in_ready}, 160'd1);
    chk("b_idle_rv", {159'd0, req_valid}, 160'd0);

    // SETUP0 restart mid-sequence
    drive(1'b1, S0, 4'd1, 32'd4, 32'h0000_0AAA, 1'b1);
    drive(1'b1, S0, 4'd1, 32'd7, 32'h0000_0BBB, 1'b1);
    drive(1'b1, S1, 4'd1, 32'h0000_9000, 32'h0003_0000, 1'b1);
    chk("c_seq_err", {159'd0, seq_err}, 160'd1);
    drive(1'b1, C01, 4'd1, 32'd1, 32'd2, 1'b1);
    chk("c_seq_err_once", {159'd0, seq_err}, 160'd0);
    drive(1'b1, C23, 4'd1, 32'd3, 32'd4, 1'b1);
    drive(1'b1, ISS, 4'd1, 32'd5, 32'd0, 1'b1);
    idle(1'b1);
    chk("c_req_valid", {159'd0, req_valid}, 160'd1);
    chk("c_desc", {155'd0, req_desc_id}, 160'd7);
    chk("c_bar", {144'd0, req_bar_addr}, 160'h0BBB);
    chk("c_flags", {144'd0, req_flags}, 160'h3);

    // reset while in GOT_C23
    idle(1'b1);
    drive(1'b1, S0,  4'd2, 32'd9, 32'd0, 1'b1);
    drive(1'b1, S1,  4'd2, 32'd0, 32'd0, 1'b1);
    drive(1'b1, C01, 4'd2, 32'd1, 32'd1, 1'b1);
    drive(1'b1, C23, 4'd2, 32'd1, 32'd1, 1'b1);
    do_reset();
    chk("d_desc_cleared", {155'd0, req_desc_id}, 160'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, ISS, 4'd2, 32'd1, 32'd0, 1'b1);
      chk($sformatf("d_no_rv%0d", k), {159'd0, req_valid}, 160'd0);
    end
    idle(1'b1);
    chk("d_err_after_iss", {159'd0, seq_err}, 160'd1);
    exp_c = {32'd34, 32'd33, 32'd32, 32'd31, 32'd30};
    send_legal(4'd5, 32'd12, 32'h0000_0042, 32'd30);
    idle(1'b1);
    chk("d_req_valid", {159'd0, req_valid}, 160'd1);
    chk("d_desc", {155'd0, req_desc_id}, 160'd12);
    chk("d_wid", {156'd0, req_wid}, 160'd5);
    chk("d_coords", req_coords, exp_c);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
